onehot_decoder_stream: RTL and testbench

//  Registered, parametrised binary-to-one-hot decoder with valid/ready handshake on both sides.

---
 rtl/onehot_decoder_stream_if.sv | 36 +++
 rtl/onehot_decoder_stream.sv | 184 ++++++++++++++++++
 tb/tb_onehot_decoder_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_stream_if.sv
// Handshake bundle for the one-hot decoder stream: an input code channel and
// an output one-hot channel, each with its own valid/ready pair.
// The master side is the code producer and one-hot consumer; the slave side
// is the decoder itself.
interface onehot_decoder_stream_if #(
    parameter int IN_WIDTH = 3,
    parameter int NUM_OUT  = 2 ** IN_WIDTH
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_code;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_OUT-1:0]  out_onehot;
    logic                out_err;

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_onehot,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_onehot,
        output out_err
    );
endinterface

// File: rtl/onehot_decoder_stream.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// A single output register holds each result; an out-of-range code produces an
// all-zero word with out_err set and is still a normal transaction.
// A self-timed sweep mode walks one hot bit from bit 0 to bit NUM_OUT-1, with a
// programmable idle gap between beats, and pulses sweep_done after the last one.
module onehot_decoder_stream #(
    parameter int IN_WIDTH  = 3,
    parameter int NUM_OUT   = 2 ** IN_WIDTH,
    parameter int SWEEP_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    onehot_decoder_stream_if.slave   bus,
    input  logic                     sweep_start,
    output logic                     sweep_busy,
    output logic                     sweep_done
);

    // Divider must be able to hold SWEEP_DIV itself.
    localparam int DIV_W = (SWEEP_DIV < 1) ? 1 : $clog2(SWEEP_DIV + 1);

    // NUM_OUT widened by one bit so the range test works even when
    // NUM_OUT == 2**IN_WIDTH (no code can then be out of range).
    localparam logic [IN_WIDTH:0] NUM_OUT_C = (IN_WIDTH + 1)'(NUM_OUT);

    localparam logic [DIV_W-1:0]   DIV_LOAD_C = DIV_W'(SWEEP_DIV);
    localparam logic [DIV_W-1:0]   DIV_ONE_C  = DIV_W'(1);
    localparam logic [NUM_OUT-1:0] FIRST_BEAT_C = NUM_OUT'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FULL    = 2'd1,
        ST_SW_OUT  = 2'd2,
        ST_SW_WAIT = 2'd3
    } state_t;

    state_t               state_r;
    logic                 out_valid_r;
    logic [NUM_OUT-1:0]   out_onehot_r;
    logic                 out_err_r;
    logic                 sweep_busy_r;
    logic                 sweep_done_r;
    logic [DIV_W-1:0]     div_r;

    logic                 in_ready_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic                 last_beat_s;
    logic [NUM_OUT-1:0]   dec_onehot_s;
    logic                 dec_err_s;

    // One-hot image of a code; bits beyond NUM_OUT-1 simply never match.
    function automatic logic [NUM_OUT-1:0] decode_onehot(input logic [IN_WIDTH-1:0] code);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            v[i] = (code == IN_WIDTH'(i));
        end
        return v;
    endfunction

    // True when the code has no corresponding output line.
    function automatic logic code_out_of_range(input logic [IN_WIDTH-1:0] code);
        return ({1'b0, code} >= NUM_OUT_C);
    endfunction

    // Input acceptance: always free in IDLE, pass-through of out_ready in FULL
    // so a fresh code can replace the one leaving on the same edge.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:    in_ready_s = 1'b1;
            ST_FULL:    in_ready_s = bus.out_ready;
            ST_SW_OUT:  in_ready_s = 1'b0;
            ST_SW_WAIT: in_ready_s = 1'b0;
            default:    in_ready_s = 1'b0;
        endcase
    end

    // Handshake qualifiers and decode of the presented code.
    always_comb begin
        in_xfer_s    = bus.in_valid & in_ready_s;
        out_xfer_s   = out_valid_r & bus.out_ready;
        last_beat_s  = out_onehot_r[NUM_OUT-1];
        dec_onehot_s = '0;
        dec_err_s    = 1'b0;
        if (code_out_of_range(bus.in_code)) begin
            dec_onehot_s = '0;
            dec_err_s    = 1'b1;
        end else begin
            dec_onehot_s = decode_onehot(bus.in_code);
            dec_err_s    = 1'b0;
        end
    end

    // Control FSM with all outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_onehot_r <= '0;
            out_err_r    <= 1'b0;
            sweep_busy_r <= 1'b0;
            sweep_done_r <= 1'b0;
            div_r        <= '0;
        end else begin
            // sweep_done is a single-cycle pulse unless re-armed below.
            sweep_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_xfer_s) begin
                        // Decode takes priority; a coincident sweep_start is dropped.
                        out_onehot_r <= dec_onehot_s;
                        out_err_r    <= dec_err_s;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_FULL;
                    end else if (sweep_start) begin
                        out_onehot_r <= FIRST_BEAT_C;
                        out_err_r    <= 1'b0;
                        out_valid_r  <= 1'b1;
                        sweep_busy_r <= 1'b1;
                        state_r      <= ST_SW_OUT;
                    end
                end

                ST_FULL: begin
                    if (out_xfer_s) begin
                        if (in_xfer_s) begin
                            out_onehot_r <= dec_onehot_s;
                            out_err_r    <= dec_err_s;
                            out_valid_r  <= 1'b1;
                        end else begin
                            out_valid_r  <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                    end
                end

                ST_SW_OUT: begin
                    if (out_xfer_s) begin
                        out_valid_r <= 1'b0;
                        if (last_beat_s) begin
                            sweep_busy_r <= 1'b0;
                            sweep_done_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            div_r   <= DIV_LOAD_C;
                            state_r <= ST_SW_WAIT;
                        end
                    end
                end

                ST_SW_WAIT: begin
                    // Reaching one (or a corrupted zero) ends the gap.
                    if (div_r <= DIV_ONE_C) begin
                        div_r        <= '0;
                        out_onehot_r <= {out_onehot_r[NUM_OUT-2:0], 1'b0};
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_SW_OUT;
                    end else begin
                        div_r <= div_r - DIV_ONE_C;
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    out_valid_r  <= 1'b0;
                    out_onehot_r <= '0;
                    out_err_r    <= 1'b0;
                    sweep_busy_r <= 1'b0;
                    div_r        <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_onehot = out_onehot_r;
    assign bus.out_err    = out_err_r;
    assign sweep_busy     = sweep_busy_r;
    assign sweep_done     = sweep_done_r;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench for onehot_decoder_stream: an 8-output instance with
// SWEEP_DIV=4 covers decode, back-pressure, sweep and reset; a 5-output
// instance covers out-of-range codes.
module tb_onehot_decoder_stream;

    logic clk;
    logic rst_n;
    logic sweep_start8, sweep_busy8, sweep_done8;
    logic sweep_start5, sweep_busy5, sweep_done5;

    int checks = 0;
    int errors = 0;

    onehot_decoder_stream_if #(.IN_WIDTH(3), .NUM_OUT(8)) bus8 ();
    onehot_decoder_stream_if #(.IN_WIDTH(3), .NUM_OUT(5)) bus5 ();

    onehot_decoder_stream #(.IN_WIDTH(3), .NUM_OUT(8), .SWEEP_DIV(4)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus8.slave),
        .sweep_start (sweep_start8),
        .sweep_busy  (sweep_busy8),
        .sweep_done  (sweep_done8)
    );

    onehot_decoder_stream #(.IN_WIDTH(3), .NUM_OUT(5), .SWEEP_DIV(4)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus5.slave),
        .sweep_start (sweep_start5),
        .sweep_busy  (sweep_busy5),
        .sweep_done  (sweep_done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1_exp [8];
    logic [7:0] t4_exp [8];

    initial begin
        t1_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        t4_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst_n         = 1'b0;
        sweep_start8  = 1'b0;
        sweep_start5  = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_code = 3'd0; bus8.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.in_code = 3'd0; bus5.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid",  32'(bus8.out_valid),  32'd0);
        check("rst_out_onehot", 32'(bus8.out_onehot), 32'd0);
        check("rst_out_err",    32'(bus8.out_err),    32'd0);
        check("rst_sweep_busy", 32'(sweep_busy8),     32'd0);
        check("rst_sweep_done", 32'(sweep_done8),     32'd0);
        check("rst5_out_valid", 32'(bus5.out_valid),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // T1: codes 0..7 back-to-back at full throughput
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.in_code = 3'(i);
            #1;
            check("t1_in_ready", 32'(bus8.in_ready), 32'd1);
            tick();
            check("t1_onehot", 32'(bus8.out_onehot), 32'(t1_exp[i]));
            check("t1_valid",  32'(bus8.out_valid),  32'd1);
            check("t1_err",    32'(bus8.out_err),    32'd0);
        end
        bus8.in_valid = 1'b0;
        tick();
        check("t1_drain_valid", 32'(bus8.out_valid), 32'd0);

        // T2: NUM_OUT=5, out-of-range code then the top legal code
        bus5.out_ready = 1'b1;
        bus5.in_valid  = 1'b1;
        bus5.in_code   = 3'd6;
        tick();
        check("t2_oor_onehot", 32'(bus5.out_onehot), 32'h00);
        check("t2_oor_err",    32'(bus5.out_err),    32'd1);
        check("t2_oor_valid",  32'(bus5.out_valid),  32'd1);
        bus5.in_code = 3'd4;
        tick();
        check("t2_top_onehot", 32'(bus5.out_onehot), 32'h10);
        check("t2_top_err",    32'(bus5.out_err),    32'd0);
        bus5.in_valid = 1'b0;
        tick();
        check("t2_drain_valid", 32'(bus5.out_valid), 32'd0);

        // T3: back-pressure in FULL with a new code waiting
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_code   = 3'd2;
        tick();
        check("t3_load_onehot", 32'(bus8.out_onehot), 32'h04);
        bus8.in_code = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_stall_in_ready", 32'(bus8.in_ready), 32'd0);
            tick();
            check("t3_stall_onehot", 32'(bus8.out_onehot), 32'h04);
            check("t3_stall_valid",  32'(bus8.out_valid),  32'd1);
        end
        bus8.out_ready = 1'b1;
        #1;
        check("t3_release_in_ready", 32'(bus8.in_ready), 32'd1);
        tick();
        check("t3_next_onehot", 32'(bus8.out_onehot), 32'h20);
        check("t3_next_valid",  32'(bus8.out_valid),  32'd1);
        bus8.in_valid = 1'b0;
        tick();
        check("t3_drain_valid", 32'(bus8.out_valid), 32'd0);

        // T4: full sweep, beats every 5 cycles, done pulse after the last
        sweep_start8 = 1'b1;
        tick();
        sweep_start8 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if ((c % 5 == 0) && (c <= 35)) begin
                check("t4_beat_valid",  32'(bus8.out_valid),  32'd1);
                check("t4_beat_onehot", 32'(bus8.out_onehot), 32'(t4_exp[c / 5]));
            end else begin
                check("t4_gap_valid", 32'(bus8.out_valid), 32'd0);
            end
            check("t4_busy",     32'(sweep_busy8),   (c <= 35) ? 32'd1 : 32'd0);
            check("t4_done",     32'(sweep_done8),   (c == 36) ? 32'd1 : 32'd0);
            check("t4_in_ready", 32'(bus8.in_ready), (c <= 35) ? 32'd0 : 32'd1);
            tick();
        end

        // T5: decode beats a simultaneous sweep_start
        bus8.in_valid = 1'b1;
        bus8.in_code  = 3'd3;
        sweep_start8  = 1'b1;
        tick();
        check("t5_onehot", 32'(bus8.out_onehot), 32'h08);
        check("t5_valid",  32'(bus8.out_valid),  32'd1);
        check("t5_busy",   32'(sweep_busy8),     32'd0);
        bus8.in_valid = 1'b0;
        sweep_start8  = 1'b0;
        tick();
        check("t5_drain_valid", 32'(bus8.out_valid), 32'd0);
        check("t5_busy_after",  32'(sweep_busy8),    32'd0);
        tick();
        check("t5_busy_later",  32'(sweep_busy8),    32'd0);
        check("t5_no_done",     32'(sweep_done8),    32'd0);

        // T6: asynchronous reset while waiting between beats
        sweep_start8 = 1'b1;
        tick();
        sweep_start8 = 1'b0;
        repeat (17) tick();
        check("t6_pre_busy",  32'(sweep_busy8),   32'd1);
        check("t6_pre_valid", 32'(bus8.out_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  32'(bus8.out_valid),  32'd0);
        check("t6_rst_onehot", 32'(bus8.out_onehot), 32'd0);
        check("t6_rst_err",    32'(bus8.out_err),    32'd0);
        check("t6_rst_busy",   32'(sweep_busy8),     32'd0);
        check("t6_rst_done",   32'(sweep_done8),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_post_in_ready", 32'(bus8.in_ready),  32'd1);
            check("t6_post_valid",    32'(bus8.out_valid), 32'd0);
            check("t6_post_busy",     32'(sweep_busy8),    32'd0);
            check("t6_post_done",     32'(sweep_done8),    32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
